logic_axi4_lite_register_slave: RTL and testbench

//  AXI4-Lite responder terminating a bus at a bank of REGISTERS read/write

---
 rtl/logic_axi4_lite_register_slave_if.sv | 38 +++
 rtl/logic_axi4_lite_register_slave.sv | 131 +++++++++++++
 tb/tb_logic_axi4_lite_register_slave.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_axi4_lite_register_slave_if.sv
// AXI4-Lite bus bundle shared by the register slave and whatever master drives it.
// Signal names follow the AXI4-Lite channel naming, without the channel prefix letters dropped.
interface logic_axi4_lite_if #(
    parameter int DATA_BYTES    = 4,
    parameter int ADDRESS_WIDTH = 8
);
    logic                       awvalid;
    logic                       awready;
    logic [ADDRESS_WIDTH-1:0]   awaddr;
    logic [2:0]                 awprot;
    logic                       wvalid;
    logic                       wready;
    logic [DATA_BYTES*8-1:0]    wdata;
    logic [DATA_BYTES-1:0]      wstrb;
    logic                       bvalid;
    logic                       bready;
    logic [1:0]                 bresp;
    logic                       arvalid;
    logic                       arready;
    logic [ADDRESS_WIDTH-1:0]   araddr;
    logic [2:0]                 arprot;
    logic                       rvalid;
    logic                       rready;
    logic [DATA_BYTES*8-1:0]    rdata;
    logic [1:0]                 rresp;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/logic_axi4_lite_register_slave.sv
// AXI4-Lite register bank endpoint: word-decoded registers with byte strobes,
// OKAY/SLVERR responses, and a one-cycle write pulse per register written.
module logic_axi4_lite_register_slave #(
    parameter int                       DATA_BYTES    = 4,
    parameter int                       ADDRESS_WIDTH = 8,
    parameter int                       REGISTERS     = 16,
    parameter logic [DATA_BYTES*8-1:0]  RESET_VALUE   = '0
) (
    input  logic                                aclk,
    input  logic                                areset_n,
    logic_axi4_lite_if.slave                    slave,
    output logic [REGISTERS*DATA_BYTES*8-1:0]   registers,
    output logic [REGISTERS-1:0]                register_write
);
    localparam int DW    = DATA_BYTES * 8;
    localparam int OFF   = $clog2(DATA_BYTES);
    localparam int IDX_W = ADDRESS_WIDTH - OFF;
    localparam logic [IDX_W:0] REG_LIMIT = (IDX_W + 1)'(REGISTERS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic is_hit(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < REG_LIMIT;
    endfunction

    logic                   aw_held, w_held;
    logic                   bvalid, rvalid;
    logic [1:0]             bresp, rresp;
    logic [DW-1:0]          rdata;

    logic [IDX_W-1:0]       aw_idx_p0;
    logic [2:0]             aw_prot_p0, ar_prot_p0;
    logic [DW-1:0]          w_data_p0;
    logic [DATA_BYTES-1:0]  w_strb_p0;

    logic                   aw_hs, w_hs, ar_hs, commit, wr_hit, rd_hit;
    logic [IDX_W-1:0]       wr_idx, rd_idx;
    logic [DW-1:0]          wr_data, rd_word;
    logic [DATA_BYTES-1:0]  wr_strb;
    logic                   unused_bits;

    assign slave.awready = !aw_held && !bvalid;
    assign slave.wready  = !w_held && !bvalid;
    assign slave.arready = !rvalid;
    assign slave.bvalid  = bvalid;
    assign slave.bresp   = bresp;
    assign slave.rvalid  = rvalid;
    assign slave.rresp   = rresp;
    assign slave.rdata   = rdata;

    assign aw_hs  = slave.awvalid && slave.awready;
    assign w_hs   = slave.wvalid && slave.wready;
    assign ar_hs  = slave.arvalid && slave.arready;
    // A channel counts toward commit whether it was parked earlier or is handshaking now.
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_idx  = aw_held ? aw_idx_p0 : slave.awaddr[ADDRESS_WIDTH-1:OFF];
    assign wr_data = w_held ? w_data_p0 : slave.wdata;
    assign wr_strb = w_held ? w_strb_p0 : slave.wstrb;
    assign rd_idx  = slave.araddr[ADDRESS_WIDTH-1:OFF];
    assign wr_hit  = is_hit(wr_idx);
    assign rd_hit  = is_hit(rd_idx);

    assign unused_bits = ^{slave.awaddr, slave.araddr, aw_prot_p0, ar_prot_p0};

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_word = registers[i*DW +: DW];
        end
    end

    // Stage p0: address/data capture, unreset
    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            aw_idx_p0  <= slave.awaddr[ADDRESS_WIDTH-1:OFF];
            aw_prot_p0 <= slave.awprot;
        end
        if (w_hs) begin
            w_data_p0 <= slave.wdata;
            w_strb_p0 <= slave.wstrb;
        end
        if (ar_hs) ar_prot_p0 <= slave.arprot;
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            bvalid         <= 1'b0;
            bresp          <= RESP_OKAY;
            rvalid         <= 1'b0;
            rresp          <= RESP_OKAY;
            rdata          <= '0;
            registers      <= {REGISTERS{RESET_VALUE}};
            register_write <= '0;
        end else begin
            register_write <= '0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < REGISTERS; i++) begin
                    if (wr_hit && wr_idx == IDX_W'(i)) begin
                        register_write[i] <= 1'b1;
                        for (int k = 0; k < DATA_BYTES; k++) begin
                            if (wr_strb[k]) registers[i*DW + k*8 +: 8] <= wr_data[k*8 +: 8];
                        end
                    end
                end
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
                if (bvalid && slave.bready) bvalid <= 1'b0;
            end

            // Read sees registers before this edge's write, so same-edge hits return old data.
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_hit ? rd_word : '0;
                rresp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid && slave.rready) begin
                rvalid <= 1'b0;
                rdata  <= '0;
                rresp  <= RESP_OKAY;
            end
        end
    end
endmodule

// File: tb/tb_logic_axi4_lite_register_slave.sv
// Directed bench for the AXI4-Lite register slave: stimulus pushes expected
// responses into queues, a negedge monitor pops and compares them.
module tb_logic_axi4_lite_register_slave;
    logic         aclk = 1'b0;
    logic         areset_n = 1'b0;
    logic [511:0] registers;
    logic [15:0]  register_write;

    int errors = 0;
    int checks = 0;

    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [15:0] exp_rw[$];

    logic_axi4_lite_if #(.DATA_BYTES(4), .ADDRESS_WIDTH(8)) bus ();

    logic_axi4_lite_register_slave #(
        .DATA_BYTES(4), .ADDRESS_WIDTH(8), .REGISTERS(16), .RESET_VALUE(32'h0)
    ) dut (
        .aclk(aclk),
        .areset_n(areset_n),
        .slave(bus.slave),
        .registers(registers),
        .register_write(register_write)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_word(input int i);
        return registers[i*32 +: 32];
    endfunction

    // Monitor: pops expectations whenever the DUT completes a response or pulses a strobe.
    always @(negedge aclk) begin
        if (areset_n) begin
            if (bus.bvalid && bus.bready) begin
                if (exp_b.size() == 0) check("b_unexpected", 1, 0);
                else check("bresp", {62'h0, bus.bresp}, {62'h0, exp_b.pop_front()});
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_r.size() == 0) check("r_unexpected", 1, 0);
                else check("rresp_rdata", {30'h0, bus.rresp, bus.rdata}, {30'h0, exp_r.pop_front()});
            end
            if (register_write != 16'h0) begin
                if (exp_rw.size() == 0) check("rw_unexpected", {48'h0, register_write}, 0);
                else check("register_write", {48'h0, register_write}, {48'h0, exp_rw.pop_front()});
            end
        end
    end

    task automatic send_aw(input logic [7:0] addr);
        int n = 0;
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.awprot  = 3'b010;
        @(negedge aclk);
        while (!bus.awready && n < 50) begin
            n++;
            @(negedge aclk);
        end
        if (n >= 50) check("aw_timeout", 1, 0);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        bus.wvalid = 1'b1;
        bus.wdata  = data;
        bus.wstrb  = strb;
        @(negedge aclk);
        while (!bus.wready && n < 50) begin
            n++;
            @(negedge aclk);
        end
        if (n >= 50) check("w_timeout", 1, 0);
        @(posedge aclk); #1;
        bus.wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] addr);
        int n = 0;
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arprot  = 3'b000;
        @(negedge aclk);
        while (!bus.arready && n < 50) begin
            n++;
            @(negedge aclk);
        end
        if (n >= 50) check("ar_timeout", 1, 0);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        check("rvalid_latency", {63'h0, bus.rvalid}, 1);
    endtask

    task automatic write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        fork
            send_aw(addr);
            send_w(data, strb);
        join
        check("bvalid_latency", {63'h0, bus.bvalid}, 1);
    endtask

    task automatic read(input logic [7:0] addr, input logic [1:0] resp, input logic [31:0] data);
        exp_r.push_back({resp, data});
        send_ar(addr);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
        bus.wvalid = 0;  bus.wdata = 0;  bus.wstrb = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0;
        bus.bready = 1;  bus.rready = 1;
        repeat (3) @(negedge aclk);
        check("reset_awready", {63'h0, bus.awready}, 1);
        check("reset_wready", {63'h0, bus.wready}, 1);
        check("reset_arready", {63'h0, bus.arready}, 1);
        check("reset_bvalid", {63'h0, bus.bvalid}, 0);
        check("reset_rvalid", {63'h0, bus.rvalid}, 0);
        check("reset_rw", {48'h0, register_write}, 0);
        check("reset_reg0", {32'h0, reg_word(0)}, 0);
        areset_n = 1'b1;
        idle(2);

        // Read of reset value
        read(8'h00, 2'b00, 32'h0);
        idle(1);

        // Same-cycle AW+W full word
        exp_b.push_back(2'b00); exp_rw.push_back(16'h0002);
        write(8'h04, 32'hDEADBEEF, 4'hF);
        idle(1);
        check("reg1_full", {32'h0, reg_word(1)}, 64'hDEADBEEF);

        // W first, AW three cycles later
        exp_b.push_back(2'b00); exp_rw.push_back(16'h0002);
        send_w(32'h11223344, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("wfirst_awready", {63'h0, bus.awready}, 1);
            check("wfirst_wready", {63'h0, bus.wready}, 0);
        end
        @(posedge aclk); #1;
        send_aw(8'h04);
        check("bvalid_after_aw", {63'h0, bus.bvalid}, 1);
        idle(1);
        check("reg1_strobe", {32'h0, reg_word(1)}, 64'hDE22BE44);

        // Miss write and miss read
        exp_b.push_back(2'b10);
        write(8'h40, 32'hCAFEF00D, 4'hF);
        idle(1);
        check("miss_reg1", {32'h0, reg_word(1)}, 64'hDE22BE44);
        check("miss_reg0", {32'h0, reg_word(0)}, 0);
        read(8'h7C, 2'b10, 32'h0);
        read(8'h04, 2'b00, 32'hDE22BE44);
        read(8'h06, 2'b00, 32'hDE22BE44);

        // Top register, single high byte
        exp_b.push_back(2'b00); exp_rw.push_back(16'h8000);
        write(8'h3C, 32'h12345678, 4'b1000);
        idle(1);
        read(8'h3F, 2'b00, 32'h12000000);

        // Zero strobe still pulses and responds OKAY
        exp_b.push_back(2'b00); exp_rw.push_back(16'h0004);
        write(8'h08, 32'hFFFFFFFF, 4'h0);
        idle(1);
        read(8'h08, 2'b00, 32'h0);

        // B backpressure with a concurrent read
        bus.bready = 1'b0;
        exp_b.push_back(2'b00); exp_rw.push_back(16'h0008);
        write(8'h0C, 32'hA5A5A5A5, 4'hF);
        fork
            for (int i = 0; i < 5; i++) begin
                @(negedge aclk);
                check("bp_bvalid", {63'h0, bus.bvalid}, 1);
                check("bp_bresp", {62'h0, bus.bresp}, 0);
                check("bp_awready", {63'h0, bus.awready}, 0);
                check("bp_wready", {63'h0, bus.wready}, 0);
            end
            read(8'h04, 2'b00, 32'hDE22BE44);
        join
        @(posedge aclk); #1;
        bus.bready = 1'b1;
        idle(2);
        check("bp_bvalid_drop", {63'h0, bus.bvalid}, 0);

        // Same-edge read and write to one register: read returns old value
        exp_b.push_back(2'b00); exp_rw.push_back(16'h0008);
        exp_r.push_back({2'b00, 32'hA5A5A5A5});
        fork
            send_aw(8'h0C);
            send_w(32'h00000001, 4'hF);
            send_ar(8'h0C);
        join
        idle(1);
        read(8'h0C, 2'b00, 32'h00000001);
        idle(1);

        // Reset mid-transaction: pending read data and held AW are dropped
        bus.rready = 1'b0;
        send_ar(8'h00);
        send_aw(8'h10);
        idle(1);
        check("pre_reset_awready", {63'h0, bus.awready}, 0);
        check("pre_reset_rvalid", {63'h0, bus.rvalid}, 1);
        #2 areset_n = 1'b0;
        #1;
        check("rst_rvalid", {63'h0, bus.rvalid}, 0);
        check("rst_bvalid", {63'h0, bus.bvalid}, 0);
        check("rst_awready", {63'h0, bus.awready}, 1);
        check("rst_wready", {63'h0, bus.wready}, 1);
        check("rst_arready", {63'h0, bus.arready}, 1);
        check("rst_rdata", {32'h0, bus.rdata}, 0);
        check("rst_reg1", {32'h0, reg_word(1)}, 0);
        check("rst_reg3", {32'h0, reg_word(3)}, 0);
        check("rst_rw", {48'h0, register_write}, 0);
        exp_r.delete();
        @(negedge aclk);
        @(negedge aclk);
        areset_n = 1'b1;
        bus.rready = 1'b1;
        idle(1);
        exp_b.push_back(2'b00); exp_rw.push_back(16'h0010);
        write(8'h10, 32'h0BADF00D, 4'hF);
        idle(1);
        read(8'h10, 2'b00, 32'h0BADF00D);
        idle(4);

        check("left_b", exp_b.size(), 0);
        check("left_r", exp_r.size(), 0);
        check("left_rw", exp_rw.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
